// File: rtl/adc_spi_responder.sv
// Serial responder for the 8-channel, 12-bit ADC frame protocol.
// The address captured in one frame selects the channel returned in the next frame.
module adc_spi_responder #(
  parameter int DATA_W     = 12,
  parameter int LEAD_ZEROS = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_50,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  din,
  input  logic [8*DATA_W-1:0]   ch_data,
  output logic                  dout,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_abort,
  output logic [2:0]            last_addr,
  output logic [CNT_W-1:0]      frame_count
);

  localparam int SH_W = LEAD_ZEROS + DATA_W;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t            state;
  logic              sclk_s1, sclk_s2, sclk_h;
  logic              cs_s1, cs_s2, cs_h;
  logic              din_s1, din_s2;
  logic [SH_W-1:0]   shreg;
  logic [4:0]        rise_cnt;
  logic [2:0]        addr_sh;
  logic [2:0]        next_ch;
  logic [SH_W-1:0]   load_val;
  logic              sclk_rise, sclk_fall, cs_rise, cs_fall;

  // cs_n idles high, so its synchronizer resets high to avoid a false frame start.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_h  <= 1'b0;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_h    <= 1'b1;
      din_s1  <= 1'b0;
      din_s2  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make each stage capture the previous
      // stage's old value, which is what turns this into a real shift chain.
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_h  <= sclk_s2;
      cs_s1   <= cs_n;
      cs_s2   <= cs_s1;
      cs_h    <= cs_s2;
      din_s1  <= din;
      din_s2  <= din_s1;
    end
  end

  assign sclk_rise = sclk_s2 & ~sclk_h;
  assign sclk_fall = ~sclk_s2 & sclk_h;
  assign cs_rise   = cs_s2 & ~cs_h;
  assign cs_fall   = ~cs_s2 & cs_h;

  assign load_val  = SH_W'(ch_data[next_ch*DATA_W +: DATA_W]);

  // shreg is cleared whenever the frame ends, so its MSB is dout directly.
  assign dout = shreg[SH_W-1];

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state       <= IDLE;
      shreg       <= '0;
      rise_cnt    <= '0;
      addr_sh     <= '0;
      next_ch     <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      last_addr   <= '0;
      frame_count <= '0;
    end else begin
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (cs_fall) begin
            shreg    <= load_val;
            rise_cnt <= '0;
            addr_sh  <= '0;
            busy     <= 1'b1;
            state    <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            if (rise_cnt == 5'd16) begin
              next_ch     <= addr_sh;
              last_addr   <= addr_sh;
              frame_count <= frame_count + 1'b1;
              frame_done  <= 1'b1;
            end else begin
              frame_abort <= 1'b1;
            end
            shreg <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            if (sclk_rise) begin
              // Address bits ride on the 3rd..5th rising edges, MSB first.
              if (rise_cnt >= 5'd2 && rise_cnt <= 5'd4)
                addr_sh <= {addr_sh[1:0], din_s2};
              if (rise_cnt != 5'd31)
                rise_cnt <= rise_cnt + 5'd1;
            end
            if (sclk_fall)
              shreg <= {shreg[SH_W-2:0], 1'b0};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: event-level protocol model plus per-cycle output compare.
module tb_adc_spi_responder;
  localparam int DATA_W = 12;
  localparam int CNT_W  = 16;
  localparam int LAT    = 3;

  logic                clk_50 = 1'b0;
  logic                reset, sclk, cs_n, din;
  logic [8*DATA_W-1:0] ch_data;
  logic                dout, busy, frame_done, frame_abort;
  logic [2:0]          last_addr;
  logic [CNT_W-1:0]    frame_count;

  adc_spi_responder #(.DATA_W(DATA_W), .LEAD_ZEROS(4), .CNT_W(CNT_W)) dut (
    .clk_50(clk_50), .reset(reset), .sclk(sclk), .cs_n(cs_n), .din(din),
    .ch_data(ch_data), .dout(dout), .busy(busy), .frame_done(frame_done),
    .frame_abort(frame_abort), .last_addr(last_addr), .frame_count(frame_count)
  );

  always #10 clk_50 = ~clk_50;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: pin-level events become visible on the outputs LAT cycles later.
  typedef enum {EV_START, EV_DONE, EV_ABORT, EV_RST} ev_kind_t;
  typedef struct {
    int       at;
    ev_kind_t kind;
    logic [2:0] addr;
  } ev_t;

  ev_t              evq[$];
  int               cyc = 0;
  bit               chk_en = 1'b0;
  logic             exp_busy = 1'b0, exp_done = 1'b0, exp_abort = 1'b0;
  logic [2:0]       exp_last = '0, m_next = '0;
  logic [CNT_W-1:0] exp_cnt = '0;

  always @(posedge clk_50) begin
    ev_t ev;
    cyc++;
    exp_done  = 1'b0;
    exp_abort = 1'b0;
    while (evq.size() > 0 && evq[0].at == cyc) begin
      ev = evq.pop_front();
      case (ev.kind)
        EV_START: exp_busy = 1'b1;
        EV_DONE: begin
          exp_busy = 1'b0;
          exp_done = 1'b1;
          exp_last = ev.addr;
          exp_cnt  = exp_cnt + 1'b1;
          m_next   = ev.addr;
        end
        EV_ABORT: begin
          exp_busy  = 1'b0;
          exp_abort = 1'b1;
        end
        default: begin
          exp_busy = 1'b0;
          exp_last = '0;
          exp_cnt  = '0;
          m_next   = '0;
        end
      endcase
    end
  end

  always @(negedge clk_50) begin
    if (chk_en) begin
      check("busy", busy, exp_busy);
      check("frame_done", frame_done, exp_done);
      check("frame_abort", frame_abort, exp_abort);
      check("last_addr", last_addr, exp_last);
      check("frame_count", frame_count, exp_cnt);
      if (!exp_busy) check("dout_idle", dout, 1'b0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_50);
    #1;
  endtask

  task automatic push(input ev_kind_t kind, input logic [2:0] a, input int lat);
    ev_t e;
    e.at   = cyc + lat;
    e.kind = kind;
    e.addr = a;
    evq.push_back(e);
  endtask

  // One frame with nrise sclk cycles; optional ch0 change at falling edge chg_at;
  // rst_end ends the frame with a reset instead of a cs_n rise.
  task automatic frame(input logic [2:0] addr, input int nrise, input int chg_at,
                       input bit rst_end, output logic [15:0] cap);
    logic [15:0] word;
    logic        exp_bit;
    int          nxt;
    word = 16'(ch_data[m_next*DATA_W +: DATA_W]);
    cap  = '0;
    cs_n = 1'b0;
    din  = 1'b0;
    push(EV_START, addr, LAT);
    tick(10);
    for (int k = 1; k <= nrise; k++) begin
      exp_bit = (k <= 16) ? word[16-k] : 1'b0;
      check("dout_bit", dout, exp_bit);
      if (k <= 16) cap = {cap[14:0], dout};
      sclk = 1'b1;
      tick(10);
      sclk = 1'b0;
      nxt  = k + 1;
      din  = (nxt >= 3 && nxt <= 5) ? addr[5-nxt] : 1'b0;
      if (k == chg_at) ch_data[DATA_W-1:0] = 12'h000;
      tick(10);
    end
    if (rst_end) begin
      reset = 1'b1;
      cs_n  = 1'b1;
      push(EV_RST, 3'd0, 1);
      tick(5);
      reset = 1'b0;
    end else begin
      cs_n = 1'b1;
      if (nrise == 16) push(EV_DONE, addr, LAT);
      else             push(EV_ABORT, addr, LAT);
    end
    tick(12);
  endtask

  logic [15:0] cap;
  int          prev;

  initial begin
    reset = 1'b1;
    sclk  = 1'b0;
    cs_n  = 1'b1;
    din   = 1'b0;
    for (int k = 0; k < 8; k++) ch_data[k*DATA_W +: DATA_W] = 12'(16'h101 * k);
    ch_data[0*DATA_W +: DATA_W] = 12'h5A3;
    ch_data[1*DATA_W +: DATA_W] = 12'h0FF;
    tick(4);
    reset  = 1'b0;
    chk_en = 1'b1;
    tick(2);
    check("rst_count", frame_count, 16'd0);
    check("rst_dout", dout, 1'b0);

    // Pipelined addressing: first frame returns channel 0.
    frame(3'd1, 16, 0, 1'b0, cap);
    check("t1_data", cap, 16'h05A3);
    check("t1_count", frame_count, 16'd1);
    check("t1_last", last_addr, 3'd1);
    frame(3'd0, 16, 0, 1'b0, cap);
    check("t1b_data", cap, 16'h00FF);

    for (int a = 2; a <= 7; a++) begin
      frame(3'(a), 16, 0, 1'b0, cap);
      prev = (a == 2) ? 0 : a - 1;
      check("t2_data", cap, (prev == 0) ? 16'h05A3 : 16'(16'h101 * prev));
    end
    check("t2_count", frame_count, 16'd8);
    check("t2_last", last_addr, 3'd7);

    // Short frame aborts and leaves the pipelined channel untouched.
    frame(3'd3, 9, 0, 1'b0, cap);
    check("t3_count", frame_count, 16'd8);
    check("t3_last", last_addr, 3'd7);
    frame(3'd0, 16, 0, 1'b0, cap);
    check("t3_data", cap, 16'h0707);

    // Long frame aborts; zeros after the 16th falling edge are checked per bit.
    frame(3'd5, 20, 0, 1'b0, cap);
    check("t4_count", frame_count, 16'd9);

    // Reset mid-frame clears next_ch back to channel 0.
    frame(3'd5, 16, 0, 1'b0, cap);
    check("t5a_data", cap, 16'h05A3);
    frame(3'd5, 4, 0, 1'b1, cap);
    check("t5_count_rst", frame_count, 16'd0);
    check("t5_last_rst", last_addr, 3'd0);
    frame(3'd2, 16, 0, 1'b0, cap);
    check("t5_data", cap, 16'h05A3);
    check("t5_count", frame_count, 16'd1);

    // ch_data is sampled only at frame start.
    ch_data[0*DATA_W +: DATA_W] = 12'hFFF;
    frame(3'd0, 16, 0, 1'b0, cap);
    check("t6a_data", cap, 16'h0202);
    frame(3'd0, 16, 6, 1'b0, cap);
    check("t6_data_hold", cap, 16'h0FFF);
    frame(3'd0, 16, 0, 1'b0, cap);
    check("t6_data_new", cap, 16'h0000);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
